// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types and helpers for the Hamming (16,11) encoder slice
//
// Contents:
//   state_t         sequencer state encoding
//   P0..P8          codeword bit positions of the parity bits
//   overall_parity  even parity over data bits and the four Hamming parity bits
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_HI = 3'd3,
    WR_LO = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;
  localparam int P8 = 8;

  // d[0] carries message bit d1; p = {p8, p4, p2, p1}
  function automatic logic overall_parity(input logic [10:0] d, input logic [3:0] p);
    return (^d) ^ (^p);
  endfunction

endpackage

// File: rtl/hamming_enc16.sv
// rtl/hamming_enc16.sv - combinational Hamming (16,11) encoder with overall parity
//
// Ports:
//   d   in  11  message, d[0] = d1 ... d[10] = d11
//   cw  out 16  codeword {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}
module hamming_enc16
  import hamming_pkg::*;
(
  input  logic [10:0] d,
  output logic [15:0] cw
);

  logic p8, p4, p2, p1;

  always_comb begin
    // Index k-1 holds message bit dk, so d11 is d[10]
    p8 = ^d[10:4];
    p4 = (^d[10:7]) ^ (^d[3:1]);
    p2 = d[10] ^ d[9] ^ d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    p1 = d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];

    cw      = '0;
    cw[15:9] = d[10:4];
    cw[P8]   = p8;
    cw[7:5]  = d[3:1];
    cw[P4]   = p4;
    cw[3]    = d[0];
    cw[P2]   = p2;
    cw[P1]   = p1;
    cw[P0]   = overall_parity(d, {p8, p4, p2, p1});
  end

endmodule

// File: rtl/hamming_enc_seq.sv
// rtl/hamming_enc_seq.sv - memory-mastering sequencer encoding N_MSG messages to codewords
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset
//   start      in   1   launch request, honoured only in IDLE or DONE
//   ack        out  1   level, high only in DONE
//   mem_addr   out  AW  data-memory byte address
//   mem_rdata  in   8   data-memory read data, valid in the same cycle as mem_addr
//   mem_we     out  1   data-memory write enable
//   mem_wdata  out  8   data-memory write data
//   busy       out  1   high while the engine owns the memory port
module hamming_enc_seq
  import hamming_pkg::*;
#(
  parameter int AW       = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int N_MSG    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic          busy
);

  localparam logic [AW-1:0] SRC  = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST  = AW'(DST_BASE);
  localparam logic [6:0]    LAST = 7'(N_MSG - 1);

  state_t        state, state_nx;
  logic [6:0]    idx;
  logic [7:0]    lo;
  logic [2:0]    hi;
  logic [15:0]   cw;
  logic [AW-1:0] off;
  logic [AW-1:0] src_lo, src_hi, dst_lo, dst_hi;
  logic          unused_rdata_hi;

  // High message byte carries only d11..d9; the rest of the byte is junk
  assign unused_rdata_hi = ^mem_rdata[7:3];

  hamming_enc16 u_enc (
    .d  ({hi, lo}),
    .cw (cw)
  );

  // Byte pair offset, wrapping modulo 2^AW with the bases
  assign off    = AW'({idx, 1'b0});
  assign src_lo = SRC + off;
  assign src_hi = src_lo + AW'(1);
  assign dst_lo = DST + off;
  assign dst_hi = dst_lo + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      lo  <= '0;
      hi  <= '0;
    end else begin
      case (state)
        IDLE:    if (start) idx <= '0;
        RD_LO:   lo <= mem_rdata;
        RD_HI:   hi <= mem_rdata[2:0];
        WR_LO:   if (idx != LAST) idx <= idx + 7'd1;
        DONE:    if (start) idx <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    ack       = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RD_LO;
      end
      RD_LO: begin
        busy     = 1'b1;
        mem_addr = src_lo;
        state_nx = RD_HI;
      end
      RD_HI: begin
        busy     = 1'b1;
        mem_addr = src_hi;
        state_nx = WR_HI;
      end
      WR_HI: begin
        busy      = 1'b1;
        mem_addr  = dst_hi;
        mem_we    = 1'b1;
        mem_wdata = cw[15:8];
        state_nx  = WR_LO;
      end
      WR_LO: begin
        busy      = 1'b1;
        mem_addr  = dst_lo;
        mem_we    = 1'b1;
        mem_wdata = cw[7:0];
        state_nx  = (idx == LAST) ? DONE : RD_LO;
      end
      DONE: begin
        ack = 1'b1;
        if (start) state_nx = RD_LO;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// tb/tb_hamming_enc_seq.sv - self-checking bench for hamming_enc_seq
module tb_hamming_enc_seq;

  localparam int AW  = 8;
  localparam int SRC = 0;
  localparam int DST = 30;
  localparam int N   = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          busy;

  always #5 clk = ~clk;

  hamming_enc_seq #(
    .AW       (AW),
    .SRC_BASE (SRC),
    .DST_BASE (DST),
    .N_MSG    (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ack       (ack),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy)
  );

  logic [7:0]  mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr, ld_data;
  logic [10:0] msg [N];
  logic [15:0] cw_exp [N];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  logic        mon_en;
  int          total = 0;
  int          bad   = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (ld_en) mem[ld_addr]  <= ld_data;
  end

  function automatic logic [15:0] ref_cw(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write must come from a busy engine and match the next scoreboard entry
  always @(negedge clk) begin
    if (mon_en && mem_we) begin
      chk("we_while_busy", {31'd0, busy}, 32'd1);
      chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {24'd0, mem_addr}, {24'd0, mon_e[15:8]});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, mon_e[7:0]});
      end
    end
  end

  task automatic poke(input int a, input logic [7:0] v);
    ld_addr = 8'(a);
    ld_data = v;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Source bytes get random junk in the unused high-byte bits
  task automatic load(input logic [7:0] fill);
    for (int a = 0; a < 2 * N + 30; a++) begin
      if (a < 2 * N) begin
        if (a % 2 == 0) poke(SRC + a, msg[a / 2][7:0]);
        else            poke(SRC + a, {5'($urandom), msg[a / 2][10:8]});
      end else begin
        poke(a, fill);
      end
    end
    for (int i = 0; i < N; i++) cw_exp[i] = ref_cw(msg[i]);
  endtask

  task automatic push_expected();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({8'(DST + 2 * i + 1), cw_exp[i][15:8]});
      exp_q.push_back({8'(DST + 2 * i), cw_exp[i][7:0]});
    end
  endtask

  task automatic check_dst(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_dst_hi"}, {24'd0, mem[DST + 2 * i + 1]}, {24'd0, cw_exp[i][15:8]});
      chk({tag, "_dst_lo"}, {24'd0, mem[DST + 2 * i]}, {24'd0, cw_exp[i][7:0]});
    end
  endtask

  task automatic run(input string tag, input int mid_start);
    int cyc;
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_ack_drop"}, {31'd0, ack}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!ack && cyc < 300) begin
      if (cyc == mid_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd60);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check_dst(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    ld_en  = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ack", {31'd0, ack}, 32'd0);
    mon_en = 1'b1;

    // All-zero messages over a non-zero destination
    for (int i = 0; i < N; i++) msg[i] = 11'h000;
    load(8'hAA);
    run("zero", -1);

    // Directed corner messages, message 2 with junk high bits
    for (int i = 0; i < N; i++) msg[i] = 11'($urandom);
    msg[0] = 11'h7FF;
    msg[1] = 11'h001;
    msg[2] = 11'h400;
    load(8'h55);
    poke(SRC + 5, 8'hFC);
    run("directed", -1);
    chk("m0_hi", {24'd0, mem[31]}, 32'hFF);
    chk("m0_lo", {24'd0, mem[30]}, 32'hFF);
    chk("m1_hi", {24'd0, mem[33]}, 32'h00);
    chk("m1_lo", {24'd0, mem[32]}, 32'h0F);
    chk("m2_hi", {24'd0, mem[35]}, 32'h81);
    chk("m2_lo", {24'd0, mem[34]}, 32'h17);

    // Random messages
    for (int i = 0; i < N; i++) msg[i] = 11'($urandom);
    load(8'hC3);
    run("random", -1);

    // Reset 20 cycles into a run, then a clean restart
    for (int i = 0; i < N; i++) msg[i] = 11'($urandom);
    load(8'hAA);
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ack", {31'd0, ack}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we", {31'd0, mem_we}, 32'd0);
    chk("abort_kept_m4", {24'd0, mem[DST + 9]}, {24'd0, cw_exp[4][15:8]});
    chk("abort_untouched_m5", {24'd0, mem[DST + 11]}, 32'hAA);
    exp_q.delete();
    @(negedge clk);
    run("restart", -1);

    // start during a run is ignored; start in DONE relaunches
    for (int i = 0; i < N; i++) msg[i] = 11'($urandom);
    load(8'h3C);
    run("midstart", 10);
    load(8'h5A);
    chk("done_ack_hold", {31'd0, ack}, 32'd1);
    run("relaunch", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_enc_seq.md
Name: hamming_enc_seq

Overview:
- Hardware sequencer for program 1 (Hamming (16,11) encode).
- Walks N_MSG 11-bit messages stored as byte pairs in data memory and feeds each through a combinational parity encoder.
- Writes each 16-bit codeword back as a byte pair, then raises ack.
- Masters the single data-memory port (dm1) while busy, replacing the software loop with a fixed-latency engine started by the same start/ack handshake as top_level.

Parameters:
- AW, 8, data-memory address width.
- SRC_BASE, 0, byte address of message 0 low byte.
- DST_BASE, 30, byte address of codeword 0 low byte.
- N_MSG, 15, message count (1..127).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- ack  out  1  program complete; level, high only in DONE.
- mem_addr  out  AW  data-memory byte address.
- mem_rdata  in  8  data-memory read data; combinational, valid same cycle as mem_addr.
- mem_we  out  1  data-memory write enable, one byte per cycle.
- mem_wdata  out  8  data-memory write data.
- busy  out  1  high in RD_LO/RD_HI/WR_HI/WR_LO; top_level muxes dm1 ownership on it.

Behaviour:
- Reset (synchronous): state=IDLE, idx=0, lo/hi latches=0; ack=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-run aborts immediately. Bytes already written stay in memory; there is no rollback.
- Message i layout: low byte at SRC_BASE+2i holds d[8:1]. High byte at SRC_BASE+2i+1 holds d[11:9] in bits [2:0]; bits [7:3] are ignored.
- Codeword layout: {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0}. [15:8] goes to DST_BASE+2i+1 and [7:0] to DST_BASE+2i.
- Parity rules:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d ^ p8^p4^p2^p1 (overall parity)
- FSM states: IDLE, RD_LO, RD_HI, WR_HI, WR_LO, DONE.
- IDLE: mem_we=0. If start is high at an edge, go to RD_LO with idx=0.
- RD_LO: mem_addr=SRC_BASE+2*idx; latch mem_rdata into lo; go to RD_HI.
- RD_HI: mem_addr=SRC_BASE+2*idx+1; latch mem_rdata[2:0] into hi; go to WR_HI.
- WR_HI: mem_addr=DST_BASE+2*idx+1; mem_we=1; mem_wdata=cw[15:8]; go to WR_LO.
- WR_LO: mem_addr=DST_BASE+2*idx; mem_we=1; mem_wdata=cw[7:0].
  - If idx==N_MSG-1, go to DONE.
  - Otherwise idx++ and go to RD_LO.
- DONE: ack=1, mem_we=0. Stay until start is seen high, then go to RD_LO with idx=0 and ack=0 on the next cycle.
- Latency: exactly 4 cycles per message. If start is sampled at edge k, ack is first high after edge k+4*N_MSG (default 60 cycles).
- start while busy is ignored. start held high across DONE re-launches immediately; the bench pulses start for one cycle.
- Address arithmetic is AW-bit and wraps modulo 2^AW. Source and destination overlap is not checked; the block sequences blindly.
- mem_we is never high outside WR_HI/WR_LO.

Decomposition:
- Package hamming_pkg:
  - state enum (typedef enum logic [2:0]).
  - codeword bit-position constants P0,P1,P2,P4,P8.
  - function for the overall parity.
- Sub-module hamming_enc16: combinational, 11-bit in, 16-bit codeword out. It is reused by the program 2 decoder check.
- hamming_enc_seq holds the FSM, index counter, byte latches and address generation.

Test Plan:
- All 15 messages = 11'h000 (bytes 00/00); pulse start → bytes 30..59 all 8'h00; ack first high exactly 60 cycles after the start edge.
- Message 0 = 11'h7FF (mem[1]=8'h07, mem[0]=8'hFF) → mem[31]=8'hFF, mem[30]=8'hFF. Message 1 = 11'h001 → mem[33]=8'h00, mem[32]=8'h0F.
- Message 2 = 11'h400 with mem[5]=8'hFC (junk in [7:3]) → treated as 3'b100; mem[35]=8'h81, mem[34]=8'h17.
- 15 random messages, compared against the parity equations above → 15/15 match; monitor asserts mem_we only in WR states, with writes alternating hi then lo address.
- Assert reset at cycle 20 of a run → next cycle ack=0, busy=0, mem_we=0. Restart with start → full correct output; ack after 60 cycles.
- start pulsed at cycle 10 of a run → ignored; ack still at cycle 60. Then pulse start in DONE → ack drops next cycle and a second identical pass completes after 60 more cycles.
